// File: rtl/mips_pkg.sv
// Shared register-file types and defaults for the MIPS-style core.
// Defaults size the standard 8 x 16-bit file; the modules stay parametrised.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_NREGS  = 8;
  localparam int unsigned DEF_AW     = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]     rf_adr_t;
  typedef logic [DEF_DATA_W-1:0] rf_data_t;

  typedef struct packed {
    logic     ena;
    rf_adr_t  adr;
    rf_data_t data;
  } rf_wr_t;

  typedef struct packed {
    logic    ena;
    rf_adr_t adr;
  } rf_rd_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between ID/WB stages (master) and the register file with scoreboard (slave).
interface regfile_sb_if
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NRD    = 3
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD-1:0]        rd_ena_i;
  logic [NRD*AW-1:0]     rd_adr_i;
  logic [NRD*DATA_W-1:0] rd_data_o;
  logic [NRD-1:0]        rd_busy_o;
  logic                  wa_ena_i;
  logic [AW-1:0]         wa_adr_i;
  logic [DATA_W-1:0]     wa_data_i;
  logic                  wb_ena_i;
  logic [AW-1:0]         wb_adr_i;
  logic [DATA_W-1:0]     wb_data_i;
  logic                  iss_ena_i;
  logic [AW-1:0]         iss_adr_i;
  logic                  clr_i;
  logic                  clr_busy_o;
  logic                  clr_done_o;
  logic [NREGS-1:0]      busy_o;

  modport master (
    output rd_ena_i, rd_adr_i, wa_ena_i, wa_adr_i, wa_data_i,
    output wb_ena_i, wb_adr_i, wb_data_i, iss_ena_i, iss_adr_i, clr_i,
    input  rd_data_o, rd_busy_o, clr_busy_o, clr_done_o, busy_o
  );

  modport slave (
    input  rd_ena_i, rd_adr_i, wa_ena_i, wa_adr_i, wa_data_i,
    input  wb_ena_i, wb_adr_i, wb_data_i, iss_ena_i, iss_adr_i, clr_i,
    output rd_data_o, rd_busy_o, clr_busy_o, clr_done_o, busy_o
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue sets, write-back clears, sweep clears one entry per cycle.
// Callers pre-gate enables (r0 filtering, sweep suppression).
module rf_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             set_ena_i,
  input  logic [AW-1:0]    set_adr_i,
  input  logic             clr_a_ena_i,
  input  logic [AW-1:0]    clr_a_adr_i,
  input  logic             clr_b_ena_i,
  input  logic [AW-1:0]    clr_b_adr_i,
  input  logic             sweep_ena_i,
  input  logic [AW-1:0]    sweep_adr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_d, busy_q;

  // Set is applied last so a new producer outranks a retiring one on the same register.
  always_comb begin
    busy_d = busy_q;
    if (sweep_ena_i) begin
      busy_d[sweep_adr_i] = 1'b0;
    end else begin
      if (clr_a_ena_i) busy_d[clr_a_adr_i] = 1'b0;
      if (clr_b_ena_i) busy_d[clr_b_adr_i] = 1'b0;
      if (set_ena_i)   busy_d[set_adr_i]   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with two write-back ports, optional bypass, issue scoreboard
// and a sequenced clear sweep.
module regfile_sb
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NREGS   = DEF_NREGS,
  parameter int unsigned NRD     = 3,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input logic         clk_i,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int unsigned   AW      = $clog2(NREGS);
  localparam logic [AW-1:0] LastAdr = AW'(NREGS - 1);

  typedef struct packed {
    logic              ena;
    logic [AW-1:0]     adr;
    logic [DATA_W-1:0] data;
  } wr_t;

  function automatic logic is_dead_r0(input logic [AW-1:0] adr);
    return ZERO_R0 && (adr == '0);
  endfunction

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  sweep_state_t      state_q;
  logic [AW-1:0]     cnt_q, cnt_nxt;
  logic              clr_busy_q, clr_done_q;
  logic              sweeping;
  wr_t               wa, wb;
  logic              iss_ena;
  logic [NREGS-1:0]  busy;

  assign sweeping = (state_q == SWEEP);
  assign cnt_nxt  = cnt_q + AW'(1);

  // Effective requests: nothing from the pipeline lands while a sweep owns the array.
  always_comb begin
    wa.ena  = bus.wa_ena_i & ~sweeping & ~is_dead_r0(bus.wa_adr_i);
    wa.adr  = bus.wa_adr_i;
    wa.data = bus.wa_data_i;
    wb.ena  = bus.wb_ena_i & ~sweeping & ~is_dead_r0(bus.wb_adr_i);
    wb.adr  = bus.wb_adr_i;
    wb.data = bus.wb_data_i;
    iss_ena = bus.iss_ena_i & ~sweeping & ~is_dead_r0(bus.iss_adr_i);
  end

  // Port B is applied after port A so MEM results win an address collision.
  always_comb begin
    regs_d = regs_q;
    if (sweeping) begin
      regs_d[cnt_q] = '0;
    end else begin
      if (wa.ena) regs_d[wa.adr] = wa.data;
      if (wb.ena) regs_d[wb.adr] = wb.data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clr_i) begin
            state_q    <= SWEEP;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
            clr_done_q <= 1'b0;
          end
        end
        SWEEP: begin
          if (cnt_q == LastAdr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
          end else begin
            cnt_q      <= cnt_nxt;
            clr_done_q <= (cnt_nxt == LastAdr);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .set_ena_i   (iss_ena),
    .set_adr_i   (bus.iss_adr_i),
    .clr_a_ena_i (wa.ena),
    .clr_a_adr_i (wa.adr),
    .clr_b_ena_i (wb.ena),
    .clr_b_adr_i (wb.adr),
    .sweep_ena_i (sweeping),
    .sweep_adr_i (cnt_q),
    .busy_o      (busy)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]     adr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign adr = bus.rd_adr_i[p*AW +: AW];

    // wa/wb enables are already low during a sweep, so bypass is naturally off then.
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (bus.rd_ena_i[p] && !is_dead_r0(adr)) begin
        bsy = busy[adr];
        if (BYPASS && wb.ena && (wb.adr == adr)) begin
          data = wb.data;
        end else if (BYPASS && wa.ena && (wa.adr == adr)) begin
          data = wa.data;
        end else begin
          data = regs_q[adr];
        end
      end
    end

    assign bus.rd_data_o[p*DATA_W +: DATA_W] = data;
    assign bus.rd_busy_o[p]                  = bsy;
  end

  assign bus.busy_o     = busy;
  assign bus.clr_busy_o = clr_busy_q;
  assign bus.clr_done_o = clr_done_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: expected values queued at stimulus time, popped at sampling.
module tb_regfile_sb;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned NP = 3;
  localparam int unsigned AW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .NREGS(NR), .NRD(NP)) bus ();

  regfile_sb #(
    .DATA_W  (DW),
    .NREGS   (NR),
    .NRD     (NP),
    .ZERO_R0 (1'b1),
    .BYPASS  (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl [NR];
  logic [DW-1:0] got, e;

  function automatic logic [DW-1:0] rd(input int p);
    return bus.rd_data_o[p*DW +: DW];
  endfunction

  task automatic idle_inputs();
    bus.rd_ena_i  = '0;
    bus.rd_adr_i  = '0;
    bus.wa_ena_i  = 1'b0;
    bus.wa_adr_i  = '0;
    bus.wa_data_i = '0;
    bus.wb_ena_i  = 1'b0;
    bus.wb_adr_i  = '0;
    bus.wb_data_i = '0;
    bus.iss_ena_i = 1'b0;
    bus.iss_adr_i = '0;
    bus.clr_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.rd_ena_i[p]          = 1'b1;
    bus.rd_adr_i[p*AW +: AW] = a;
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wa_ena_i  = 1'b1;
    bus.wa_adr_i  = a;
    bus.wa_data_i = d;
  endtask

  task automatic write_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wb_ena_i  = 1'b1;
    bus.wb_adr_i  = a;
    bus.wb_data_i = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    #2 rst_n = 1'b0;
    set_rd(0, 3);
    set_rd(1, 7);
    #1;
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    e = exp_q.pop_front(); got = {8'h0, bus.busy_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_busy: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = {14'h0, bus.clr_busy_o, bus.clr_done_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_clr: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = rd(0) | rd(1); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_read: got %h expected %h", got, e); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    write_a(3, 16'h1234);
    set_rd(0, 3);
    mdl[3] = 16'h1234;
    exp_q.push_back(16'h1234);
    #1;
    e = exp_q.pop_front(); got = rd(0); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL wr_bypass_a: got %h expected %h", got, e); end
    tick();
    bus.wa_ena_i = 1'b0;
    bus.rd_ena_i[1] = 1'b0;
    bus.rd_adr_i[1*AW +: AW] = 3;
    exp_q.push_back(mdl[3]);
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); got = rd(0); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL wr_readback: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = rd(1) | DW'(bus.rd_busy_o[1]); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL rd_disabled: got %h expected %h", got, e); end
    idle_inputs();
  endtask

  task automatic test_conflict();
    write_a(5, 16'hAAAA);
    write_b(5, 16'h5555);
    set_rd(2, 5);
    mdl[5] = 16'h5555;
    exp_q.push_back(16'h5555);
    #1;
    e = exp_q.pop_front(); got = rd(2); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL conflict_bypass: got %h expected %h", got, e); end
    tick();
    idle_inputs();
    set_rd(2, 5);
    exp_q.push_back(mdl[5]);
    #1;
    e = exp_q.pop_front(); got = rd(2); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL conflict_b_wins: got %h expected %h", got, e); end
    // Distinct addresses: each read must pick its own port's data.
    write_a(5, 16'h1111);
    write_b(6, 16'h6666);
    set_rd(0, 6);
    set_rd(1, 5);
    mdl[5] = 16'h1111;
    mdl[6] = 16'h6666;
    exp_q.push_back(16'h6666);
    exp_q.push_back(16'h1111);
    #1;
    e = exp_q.pop_front(); got = rd(0); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL bypass_b_split: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = rd(1); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL bypass_a_split: got %h expected %h", got, e); end
    tick();
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    bus.iss_ena_i = 1'b1;
    bus.iss_adr_i = 2;
    tick();
    idle_inputs();
    set_rd(0, 2);
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0001);
    #1;
    e = exp_q.pop_front(); got = {8'h0, bus.busy_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sb_issue: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = DW'(bus.rd_busy_o[0]); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sb_rd_busy: got %h expected %h", got, e); end
    write_a(2, 16'h2222);
    bus.iss_ena_i = 1'b1;
    bus.iss_adr_i = 2;
    mdl[2] = 16'h2222;
    tick();
    idle_inputs();
    set_rd(0, 2);
    exp_q.push_back(16'h0004);
    exp_q.push_back(mdl[2]);
    #1;
    e = exp_q.pop_front(); got = {8'h0, bus.busy_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sb_issue_wins: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = rd(0); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sb_issue_data: got %h expected %h", got, e); end
    bus.iss_ena_i = 1'b1;
    bus.iss_adr_i = 6;
    write_b(2, 16'h2BBB);
    mdl[2] = 16'h2BBB;
    tick();
    idle_inputs();
    exp_q.push_back(16'h0040);
    #1;
    e = exp_q.pop_front(); got = {8'h0, bus.busy_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sb_wb_clear: got %h expected %h", got, e); end
    write_a(6, 16'h0606);
    mdl[6] = 16'h0606;
    tick();
    idle_inputs();
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); got = {8'h0, bus.busy_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sb_wa_clear: got %h expected %h", got, e); end
  endtask

  task automatic test_r0();
    write_a(0, 16'hFFFF);
    bus.iss_ena_i = 1'b1;
    bus.iss_adr_i = 0;
    set_rd(0, 0);
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); got = rd(0); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL r0_no_bypass: got %h expected %h", got, e); end
    tick();
    bus.wa_ena_i = 1'b0;
    bus.iss_ena_i = 1'b0;
    write_b(0, 16'hC0DE);
    tick();
    idle_inputs();
    set_rd(0, 0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); got = rd(0); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL r0_read: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = {7'h0, bus.busy_o[0], 7'h0, bus.rd_busy_o[0]}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL r0_busy: got %h expected %h", got, e); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, b;
    logic [DW-1:0] da, db;
    for (int i = 0; i < 12; i++) begin
      a  = AW'(1 + $urandom_range(0, 6));
      b  = AW'(1 + $urandom_range(0, 6));
      da = DW'($urandom);
      db = DW'($urandom);
      write_a(a, da);
      write_b(b, db);
      set_rd(0, a);
      mdl[a] = da;
      mdl[b] = db;
      exp_q.push_back(mdl[a]);
      #1;
      e = exp_q.pop_front(); got = rd(0); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_bypass[%0d]: got %h expected %h", i, got, e); end
      tick();
    end
    idle_inputs();
    for (int r = 1; r < NR; r++) begin
      set_rd(r % NP, AW'(r));
      exp_q.push_back(mdl[r]);
      #1;
      e = exp_q.pop_front(); got = rd(r % NP); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL b2b_read r%0d: got %h expected %h", r, got, e); end
    end
    idle_inputs();
  endtask

  task automatic test_sweep();
    for (int r = 1; r < NR; r++) begin
      write_a(AW'(r), DW'(r));
      mdl[r] = DW'(r);
      tick();
    end
    idle_inputs();
    bus.iss_ena_i = 1'b1;
    bus.iss_adr_i = 4;
    tick();
    idle_inputs();
    bus.clr_i = 1'b1;
    tick();
    idle_inputs();
    for (int c = 1; c <= NR; c++) begin
      exp_q.push_back({14'h0, 1'b1, (c == NR)});
      e = exp_q.pop_front(); got = {14'h0, bus.clr_busy_o, bus.clr_done_o}; n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL sweep_flags c%0d: got %h expected %h", c, got, e); end
      if (c == 3) begin
        write_a(1, 16'hBEEF);
        bus.iss_ena_i = 1'b1;
        bus.iss_adr_i = 1;
        set_rd(0, 1);
        set_rd(1, 7);
        exp_q.push_back('0);
        exp_q.push_back(16'h0007);
        #1;
        e = exp_q.pop_front(); got = rd(0); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL sweep_no_bypass: got %h expected %h", got, e); end
        e = exp_q.pop_front(); got = rd(1); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL sweep_pending_r7: got %h expected %h", got, e); end
      end
      if (c == 5) bus.clr_i = 1'b1;
      tick();
      idle_inputs();
    end
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    exp_q.push_back('0);
    exp_q.push_back('0);
    e = exp_q.pop_front(); got = {14'h0, bus.clr_busy_o, bus.clr_done_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sweep_end_flags: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = {8'h0, bus.busy_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sweep_busy_clr: got %h expected %h", got, e); end
    for (int r = 1; r < NR; r++) begin
      set_rd(0, AW'(r));
      exp_q.push_back(mdl[r]);
      #1;
      e = exp_q.pop_front(); got = rd(0); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL sweep_clear r%0d: got %h expected %h", r, got, e); end
    end
    idle_inputs();
    tick();
    exp_q.push_back('0);
    e = exp_q.pop_front(); got = DW'(bus.clr_busy_o); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sweep_no_restart: got %h expected %h", got, e); end
  endtask

  task automatic test_sweep_abort();
    write_a(3, 16'h0033);
    tick();
    write_a(6, 16'h0066);
    tick();
    idle_inputs();
    bus.clr_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); got = DW'(bus.clr_busy_o); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL abort_mid_sweep: got %h expected %h", got, e); end
    #2 rst_n = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    set_rd(0, 6);
    #1;
    exp_q.push_back('0);
    exp_q.push_back(mdl[6]);
    e = exp_q.pop_front(); got = {14'h0, bus.clr_busy_o, bus.clr_done_o}; n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL abort_async_flags: got %h expected %h", got, e); end
    e = exp_q.pop_front(); got = rd(0); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL abort_async_data: got %h expected %h", got, e); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_q.push_back('0);
      e = exp_q.pop_front(); got = DW'(bus.clr_busy_o); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL abort_not_resumed k%0d: got %h expected %h", k, got, e); end
    end
    write_b(6, 16'h6060);
    mdl[6] = 16'h6060;
    tick();
    idle_inputs();
    set_rd(2, 6);
    exp_q.push_back(mdl[6]);
    #1;
    e = exp_q.pop_front(); got = rd(2); n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL abort_write_after: got %h expected %h", got, e); end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_scoreboard();
    test_r0();
    test_back_to_back();
    test_sweep();
    test_sweep_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
